// File: rtl/grf_wr_arbiter.sv
// Two-requester round-robin write arbiter for the general register file.
// It also keeps a pending-write scoreboard for RAW hazard checks and counts committed writes.
module grf_wr_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [4:0]    req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic [DW-1:0] req0_pc,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [4:0]    req1_addr,
  input  logic [DW-1:0] req1_data,
  input  logic [DW-1:0] req1_pc,
  output logic          req1_ready,
  output logic          grf_we,
  output logic [4:0]    grf_a3,
  output logic [DW-1:0] grf_wd,
  output logic [DW-1:0] grf_pc,
  input  logic          busy_set,
  input  logic [4:0]    busy_addr,
  input  logic [4:0]    rs_a,
  input  logic [4:0]    rs_b,
  output logic          hazard,
  output logic [31:0]   busy_vec,
  output logic [15:0]   wr_count
);

  // last_grant_q=1 means req0 was granted most recently; the reset value favours req0.
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [4:0]    a3_q, a3_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [31:0]   busy_q, busy_d;
  logic [15:0]   count_q, count_d;

  logic          acc;
  logic          commit;
  logic [4:0]    acc_addr;
  logic [DW-1:0] acc_data;
  logic [DW-1:0] acc_pc;

  assign req0_ready = reset & req0_valid & (~req1_valid | ~last_grant_q);
  assign req1_ready = reset & req1_valid & (~req0_valid |  last_grant_q);

  assign acc      = req0_ready | req1_ready;
  assign acc_addr = req1_ready ? req1_addr : req0_addr;
  assign acc_data = req1_ready ? req1_data : req0_data;
  assign acc_pc   = req1_ready ? req1_pc   : req0_pc;
  // Writes to r0 are accepted but dropped: no port strobe, scoreboard or count effect.
  assign commit   = acc & (acc_addr != 5'd0);

  always_comb begin
    last_grant_d = last_grant_q;
    if (req0_ready) begin
      last_grant_d = 1'b1;
    end else if (req1_ready) begin
      last_grant_d = 1'b0;
    end

    we_d = commit;
    a3_d = acc ? acc_addr : a3_q;
    wd_d = acc ? acc_data : wd_q;
    pc_d = acc ? acc_pc   : pc_q;

    // Clear first, then set, so a same-cycle set of the same index wins.
    busy_d = busy_q;
    if (commit) begin
      busy_d[acc_addr] = 1'b0;
    end
    if (busy_set && (busy_addr != 5'd0)) begin
      busy_d[busy_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;

    count_d = count_q;
    if (commit && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b0;
      we_q         <= 1'b0;
      a3_q         <= '0;
      wd_q         <= '0;
      pc_q         <= '0;
      busy_q       <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      a3_q         <= a3_d;
      wd_q         <= wd_d;
      pc_q         <= pc_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
    end
  end

  assign grf_we   = we_q;
  assign grf_a3   = a3_q;
  assign grf_wd   = wd_q;
  assign grf_pc   = pc_q;
  assign busy_vec = busy_q;
  assign wr_count = count_q;
  assign hazard   = ((rs_a != 5'd0) & busy_q[rs_a]) | ((rs_b != 5'd0) & busy_q[rs_b]);

endmodule

// File: doc/grf_wr_arbiter.md
GRF_WR_ARBITER -- requirements
Module: grf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the write-data and PC width.
REQ-002 clk  input  1  The block SHALL use this single clock; all state updates on its rising edge.
REQ-003 reset  input  1  The block SHALL treat this as an asynchronous, active-low reset (0 = reset asserted).
REQ-004 req0_valid / req1_valid  input  1 each  The block SHALL treat these as the requester write-request strobes.
REQ-005 req0_addr / req1_addr  input  5 each  The block SHALL treat these as the destination register indexes.
REQ-006 req0_data / req1_data  input  DW each  The block SHALL treat these as the write data.
REQ-007 req0_pc / req1_pc  input  DW each  The block SHALL treat these as the instruction PCs carried for the trace.
REQ-008 req0_ready / req1_ready  output  1 each  The block SHALL drive these as combinational grant/accept.
REQ-009 grf_we, grf_a3, grf_wd, grf_pc  output  1/5/DW/DW  The block SHALL drive these as the registered register-file write port.
REQ-010 busy_set, busy_addr  input  1/5  The block SHALL accept these as the issue-time pending-write mark.
REQ-011 rs_a, rs_b  input  5 each  The block SHALL accept these as the source indexes for the hazard query.
REQ-012 hazard  output  1  The block SHALL drive this as the combinational read-after-write hazard flag.
REQ-013 busy_vec  output  32  The block SHALL drive this as the pending-write scoreboard.
REQ-014 wr_count  output  16  The block SHALL drive this as the count of committed writes.

Function
REQ-015 A request SHALL be accepted in the cycle where reqN_valid=1 and reqN_ready=1.
REQ-016 When exactly one requester is valid, that requester SHALL receive ready=1.
REQ-017 When both are valid, ready SHALL go to the requester not granted most recently (round robin); the other SHALL see ready=0 and keep its request stable.
REQ-018 last_grant SHALL update only on an accepted request; after reset, req0 SHALL win the first contention.
REQ-019 An accept at edge N SHALL produce grf_we=1 with grf_a3/grf_wd/grf_pc equal to the accepted addr/data/pc for exactly cycle N+1 (latency 1).
REQ-020 A cycle with no accept SHALL yield grf_we=0 in the next cycle; grf_a3/grf_wd/grf_pc SHALL hold their previous values.
REQ-021 A request with addr=0 SHALL be accepted normally but SHALL produce grf_we=0, SHALL NOT touch busy_vec, and SHALL NOT increment wr_count.
REQ-022 busy_set=1 with busy_addr≠0 SHALL set busy_vec[busy_addr] at the next edge; busy_addr=0 SHALL be ignored.
REQ-023 An accepted nonzero write SHALL clear busy_vec[addr] at the next edge.
REQ-024 A set and a clear of the same index in the same cycle SHALL leave the bit set.
REQ-025 hazard SHALL equal (rs_a≠0 & busy_vec[rs_a]) | (rs_b≠0 & busy_vec[rs_b]), evaluated combinationally on the current busy_vec.
REQ-026 wr_count SHALL increment by 1 per committed write (grf_we=1 cycle) and SHALL saturate at 16'hFFFF.
REQ-027 busy_vec[0] SHALL always read 0.

Reset
REQ-028 Asserting reset (0) SHALL immediately clear grf_we, grf_a3, grf_wd, grf_pc, busy_vec, wr_count and last_grant, independent of clk.
REQ-029 While reset=0, req0_ready and req1_ready SHALL be 0 and no request SHALL be accepted.
REQ-030 A write latched before reset asserts mid-operation SHALL be discarded; grf_we SHALL read 0 in the first cycle after deassertion.
REQ-031 Reset deassertion SHALL take effect at the first rising clk edge after reset returns to 1.

Verification
REQ-032 req0 only, addr=5, data=32'hDEADBEEF, pc=32'h3000 -> ready0=1 same cycle; next cycle grf_we=1, grf_a3=5, grf_wd=32'hDEADBEEF, grf_pc=32'h3000; wr_count=1.
REQ-033 Both valid for 3 consecutive cycles after reset (req0 addr=1, req1 addr=2) -> grants req0, req1, req0; grf_a3 sequence 1, 2, 1.
REQ-034 busy_set with busy_addr=7, then rs_a=7 -> hazard=1; accepted write to 7 -> busy_vec[7]=0 and hazard=0 the following cycle.
REQ-035 busy_set with busy_addr=9 plus an accepted write to 9 in the same cycle -> busy_vec[9]=1 afterwards.
REQ-036 req1 addr=0, data=32'h1234 -> ready1=1; next cycle grf_we=0; busy_vec and wr_count unchanged; busy_set with busy_addr=0 -> busy_vec stays 0.
REQ-037 Accept a write to addr=3, then assert reset asynchronously mid-cycle before the next edge -> all outputs 0 immediately; grf_we=0 after release; no write to 3 appears.
